// File: rtl/alu_resp_checker.sv
// Two-stage response monitor for the ALU: S1 captures a flagged sample, S2 recomputes the
// golden result, compares it with the ALU's answer and keeps counters and first-failure capture.
module alu_resp_checker #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             chk_valid,
   input  logic             chk_clr,
   input  logic [WIDTH-1:0] SrcA,
   input  logic [WIDTH-1:0] SrcB,
   input  logic [3:0]       ALU_Opt,
   input  logic [WIDTH-1:0] ALU_Res,
   input  logic             Zero,
   output logic             chk_done,
   output logic             chk_pass,
   output logic             err_sticky,
   output logic             ill_sticky,
   output logic [CNT_W-1:0] op_cnt,
   output logic [CNT_W-1:0] err_cnt,
   output logic [3:0]       first_opt,
   output logic [WIDTH-1:0] first_exp,
   output logic [WIDTH-1:0] first_got
);

   localparam logic [3:0] OP_AND = 4'b0000;
   localparam logic [3:0] OP_OR  = 4'b0001;
   localparam logic [3:0] OP_ADD = 4'b0010;
   localparam logic [3:0] OP_SUB = 4'b0110;
   localparam logic [3:0] OP_SLT = 4'b0111;
   localparam logic [3:0] OP_NOR = 4'b1100;

   function automatic logic is_legal(input logic [3:0] opt);
      return (opt == OP_AND) || (opt == OP_OR) || (opt == OP_ADD) ||
             (opt == OP_SUB) || (opt == OP_SLT) || (opt == OP_NOR);
   endfunction

   function automatic logic [WIDTH-1:0] golden(input logic [3:0] opt,
                                               input logic signed [WIDTH-1:0] a,
                                               input logic signed [WIDTH-1:0] b);
      logic [WIDTH-1:0] r;
      r = '0;
      case (opt)
         OP_AND:  r = a & b;
         OP_OR:   r = a | b;
         OP_ADD:  r = a + b;
         OP_SUB:  r = a - b;
         OP_SLT:  r = {{(WIDTH-1){1'b0}}, (a < b)};
         OP_NOR:  r = ~(a | b);
         default: r = '0;
      endcase
      return r;
   endfunction

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
      return (&c) ? c : c + 1'b1;
   endfunction

   logic clr;
   assign clr = rst | chk_clr;

   // Stage 1: capture the flagged sample
   logic                    vld_p1_q;
   logic signed [WIDTH-1:0] a_p1_q, b_p1_q;
   logic [3:0]              opt_p1_q;
   logic [WIDTH-1:0]        res_p1_q;
   logic                    zero_p1_q;

   always_ff @(posedge clk) begin
      if (clr) vld_p1_q <= 1'b0;
      else     vld_p1_q <= chk_valid;
   end

   always_ff @(posedge clk) begin
      if (chk_valid) begin
         a_p1_q    <= SrcA;
         b_p1_q    <= SrcB;
         opt_p1_q  <= ALU_Opt;
         res_p1_q  <= ALU_Res;
         zero_p1_q <= Zero;
      end
   end

   // Stage 2: golden compare and result bookkeeping
   logic [WIDTH-1:0] exp_p1;
   logic             legal_p1, match_p1;

   assign exp_p1   = golden(opt_p1_q, a_p1_q, b_p1_q);
   assign legal_p1 = is_legal(opt_p1_q);
   assign match_p1 = (res_p1_q == exp_p1) && (zero_p1_q == (exp_p1 == '0));

   logic             done_d, done_q, pass_d, pass_q;
   logic             errs_d, errs_q, ills_d, ills_q;
   logic [CNT_W-1:0] opc_d, opc_q, errc_d, errc_q;
   logic [3:0]       fopt_d, fopt_q;
   logic [WIDTH-1:0] fexp_d, fexp_q, fgot_d, fgot_q;

   always_comb begin
      done_d = 1'b0;
      pass_d = 1'b0;
      errs_d = errs_q;
      ills_d = ills_q;
      opc_d  = opc_q;
      errc_d = errc_q;
      fopt_d = fopt_q;
      fexp_d = fexp_q;
      fgot_d = fgot_q;
      if (vld_p1_q) begin
         if (!legal_p1) begin
            ills_d = 1'b1;
         end else begin
            done_d = 1'b1;
            pass_d = match_p1;
            opc_d  = sat_inc(opc_q);
            if (!match_p1) begin
               errc_d = sat_inc(errc_q);
               errs_d = 1'b1;
               // Only the very first mismatch since reset/clear is captured.
               if (!errs_q) begin
                  fopt_d = opt_p1_q;
                  fexp_d = exp_p1;
                  fgot_d = res_p1_q;
               end
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         done_q <= 1'b0;
         pass_q <= 1'b0;
         errs_q <= 1'b0;
         ills_q <= 1'b0;
         opc_q  <= '0;
         errc_q <= '0;
         fopt_q <= '0;
         fexp_q <= '0;
         fgot_q <= '0;
      end else begin
         done_q <= done_d;
         pass_q <= pass_d;
         errs_q <= errs_d;
         ills_q <= ills_d;
         opc_q  <= opc_d;
         errc_q <= errc_d;
         fopt_q <= fopt_d;
         fexp_q <= fexp_d;
         fgot_q <= fgot_d;
      end
   end

   assign chk_done   = done_q;
   assign chk_pass   = pass_q;
   assign err_sticky = errs_q;
   assign ill_sticky = ills_q;
   assign op_cnt     = opc_q;
   assign err_cnt    = errc_q;
   assign first_opt  = fopt_q;
   assign first_exp  = fexp_q;
   assign first_got  = fgot_q;

endmodule
